sw_conditioner: RTL and testbench

Conditions the raw board switches before they reach the platform's PIO switch inputs: init, stop and the 2-bit selector. Each channel is synchronised into the clock domain, debounced with a per-channel counter, and presented as a stable level. Single-cycle event pulses are also produced for fabric logic that needs edges instead of levels. The block sits between the top-level switch pins and the `platform` instance's `pio_sw_*_external_connection_export` inputs.

---
 rtl/sw_conditioner_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 74 +++++++
 rtl/sw_conditioner.sv | 62 ++++++
 tb/tb_sw_conditioner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sw_conditioner_pkg.sv
// Shared types and helpers for the switch conditioner: debounce FSM states,
// counter sizing and synchroniser depth.
package sw_conditioner_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_t;

    localparam int SYNC_STAGES = 2;

    // Bits needed to hold 0..n-1; at least one bit so the counter always exists.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, then a debounce FSM that only
// accepts a new W-bit word after DEBOUNCE_CYCLES identical samples.
module debounce_channel
    import sw_conditioner_pkg::*;
#(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level,
    output logic         changed
);

    localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][W-1:0] sync;
    logic [W-1:0]                  sample;
    logic [W-1:0]                  cand;
    logic [CW-1:0]                 cnt;
    db_state_t                     state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    assign sample = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STABLE;
            cand    <= '0;
            cnt     <= '0;
            level   <= '0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            case (state)
                STABLE: begin
                    if (sample != level) begin
                        cand  <= sample;
                        cnt   <= CW'(1);
                        state <= SETTLING;
                    end
                end
                SETTLING: begin
                    if (sample == level) begin
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (sample != cand) begin
                        // Multi-bit word moved to a third value: restart on it.
                        cand <= sample;
                        cnt  <= CW'(1);
                    end else if (cnt == LAST) begin
                        level   <= cand;
                        changed <= 1'b1;
                        cnt     <= '0;
                        state   <= STABLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= STABLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sw_conditioner.sv
// Board switch conditioner: synchronised, debounced levels for the platform
// PIO inputs plus single-cycle edge pulses for fabric logic.
module sw_conditioner
    import sw_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       sw_init_raw,
    input  logic       sw_stop_raw,
    input  logic [1:0] sw_selector_raw,
    output logic       pio_sw_init,
    output logic       pio_sw_stop,
    output logic [1:0] pio_sw_selector,
    output logic       init_rise,
    output logic       stop_rise,
    output logic       selector_changed
);

    logic [SYNC_STAGES-1:0] rel;
    logic                   rst_int;
    logic                   init_chg;
    logic                   stop_chg;

    // Reset asserts immediately but releases only after two clean edges.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) rel <= '0;
        else             rel <= {rel[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_int = ~rel[SYNC_STAGES-1];

    debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_init (
        .clk     (clk_clk),
        .rst     (rst_int),
        .raw     (sw_init_raw),
        .level   (pio_sw_init),
        .changed (init_chg)
    );

    debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk     (clk_clk),
        .rst     (rst_int),
        .raw     (sw_stop_raw),
        .level   (pio_sw_stop),
        .changed (stop_chg)
    );

    debounce_channel #(.W(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk     (clk_clk),
        .rst     (rst_int),
        .raw     (sw_selector_raw),
        .level   (pio_sw_selector),
        .changed (selector_changed)
    );

    // Both terms are registered, so the rise pulses stay glitch-free.
    assign init_rise = init_chg & pio_sw_init;
    assign stop_rise = stop_chg & pio_sw_stop;

endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench for sw_conditioner with a short debounce window.
module tb_sw_conditioner;

    localparam int D = 4;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       sw_init_raw = 1'b1;
    logic       sw_stop_raw = 1'b1;
    logic [1:0] sw_selector_raw = 2'b11;
    logic       pio_sw_init;
    logic       pio_sw_stop;
    logic [1:0] pio_sw_selector;
    logic       init_rise;
    logic       stop_rise;
    logic       selector_changed;

    sw_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .sw_init_raw      (sw_init_raw),
        .sw_stop_raw      (sw_stop_raw),
        .sw_selector_raw  (sw_selector_raw),
        .pio_sw_init      (pio_sw_init),
        .pio_sw_stop      (pio_sw_stop),
        .pio_sw_selector  (pio_sw_selector),
        .init_rise        (init_rise),
        .stop_rise        (stop_rise),
        .selector_changed (selector_changed)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        init;
        logic        stop;
        logic [1:0]  sel;
        logic        ir;
        logic        sr;
        logic        sc;
    } ev_t;

    ev_t  q[$];
    int   tests = 0;
    int   fails = 0;
    logic done = 1'b0;
    logic [3:0] prev = 4'h0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic expect_ev(input int c, input logic i, input logic s,
                             input logic [1:0] sel, input logic ir,
                             input logic sr, input logic sc);
        ev_t e;
        e = '{cyc: 32'(c), init: i, stop: s, sel: sel, ir: ir, sr: sr, sc: sc};
        q.push_back(e);
    endtask

    // Stimulus: each accepted change is expected D+2 cycles after the drive
    // (D+4 when the drive coincides with reset release).
    initial begin
        tick(3);
        reset_reset = 1'b0;
        expect_ev(cyc + D + 4, 1, 1, 2'b11, 1, 1, 1);
        tick(15);

        sw_init_raw = 0; sw_stop_raw = 0; sw_selector_raw = 2'b00;
        expect_ev(cyc + D + 2, 0, 0, 2'b00, 0, 0, 1);
        tick(12);

        sw_stop_raw = 1;
        expect_ev(cyc + D + 2, 0, 1, 2'b00, 0, 1, 0);
        tick(12);
        sw_stop_raw = 0;
        expect_ev(cyc + D + 2, 0, 0, 2'b00, 0, 0, 0);
        tick(12);

        sw_init_raw = 1; tick(3); sw_init_raw = 0;
        tick(12);

        sw_selector_raw = 2'b01; tick(2);
        sw_selector_raw = 2'b11;
        expect_ev(cyc + D + 2, 0, 0, 2'b11, 0, 0, 1);
        tick(12);

        sw_selector_raw = 2'b00;
        expect_ev(cyc + D + 2, 0, 0, 2'b00, 0, 0, 1);
        tick(12);

        sw_init_raw = 1; sw_selector_raw = 2'b10;
        expect_ev(cyc + D + 2, 1, 0, 2'b10, 1, 0, 1);
        tick(12);

        sw_init_raw = 0; sw_selector_raw = 2'b00;
        expect_ev(cyc + D + 2, 0, 0, 2'b00, 0, 0, 1);
        tick(12);

        sw_init_raw = 1; tick(2);
        reset_reset = 1'b1; tick(1);
        reset_reset = 1'b0;
        expect_ev(cyc + D + 4, 1, 0, 2'b00, 1, 0, 0);
        tick(15);

        done = 1'b1;
        tick(4);
    end

    // Monitor: any pulse or level change is an event that must match the
    // head of the queue, including the cycle it occurs in.
    initial begin
        ev_t        e;
        logic [6:0] cur;
        forever begin
            @(negedge clk_clk);
            #1;
            cur = {pio_sw_init, pio_sw_stop, pio_sw_selector,
                   init_rise, stop_rise, selector_changed};
            if (done) begin
                tests++;
                if (q.size() != 0) begin
                    fails++;
                    $display("FAIL drain: %0d expected events never seen, required 0", q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end else if (reset_reset) begin
                tests++;
                if (cur != 7'b0) begin
                    fails++;
                    $display("FAIL reset_zero: got %b required 0000000 at cyc %0d", cur, cyc);
                end
                prev = cur[6:3];
            end else if (cur[2:0] != 3'b0 || cur[6:3] != prev) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %b at cyc %0d, required no event", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if ({32'(cyc), cur} != e) begin
                        fails++;
                        $display("FAIL event: got cyc %0d out %b, required cyc %0d out %b",
                                 cyc, cur, e.cyc, {e.init, e.stop, e.sel, e.ir, e.sr, e.sc});
                    end
                end
                prev = cur[6:3];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
